seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all ports are listed below, clock and reset first.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous reset, active low.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 op_a  input  32  multiplicand; sampled on the edge where start is accepted.
REQ-006 op_b  input  32  multiplier; sampled on the edge where start is accepted.
REQ-007 busy  output  1  high while the state is RUN or DONE.
REQ-008 done  output  1  one-cycle pulse; high in the DONE state.
REQ-009 product  output  64  result register, valid while done is high.
REQ-010 add_a  output  32  operand A driven to the downstream 32-bit ripple/lookahead adder.
REQ-011 add_b  output  32  operand B driven to the adder.
REQ-012 add_cin  output  1  adder carry-in; constant 0.
REQ-013 add_sum  input  32  sum returned by the adder, same cycle, combinational.
REQ-014 add_cout  input  1  carry-out returned by the adder.

Function
REQ-015 The block SHALL implement an unsigned 32x32->64 shift-add multiply using only the external adder for the accumulation.
REQ-016 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-017 IDLE->RUN when start=1: load mcand<=op_a, mplr<=op_b, acc_hi<=0, count<=0.
REQ-018 In RUN: add_a=acc_hi; add_b=mplr[0] ? mcand : 0; each edge {acc_hi,mplr}<={add_cout,add_sum,mplr[31:1]}; count<=count+1.
REQ-019 RUN->DONE on the edge where count==31, i.e. after exactly 32 RUN cycles.
REQ-020 On entry to DONE, product SHALL take the value {acc_hi,mplr}, with the final shift included.
REQ-021 DONE->IDLE unconditionally after one cycle.
REQ-022 Latency SHALL be fixed: done is high in the 33rd cycle after the accepting edge.
REQ-023 In IDLE and DONE, add_a and add_b SHALL be 0.
REQ-024 start asserted in RUN or DONE SHALL be ignored; there is no queueing.
REQ-025 start held high continuously SHALL begin a new operation on the first IDLE cycle after DONE, giving back-to-back throughput of one result per 34 cycles.
REQ-026 product SHALL hold its value until the next entry to DONE; it is not cleared on start.
REQ-027 count SHALL be 5 bits and SHALL NOT wrap within an operation.

Reset
REQ-028 While rst_n=0: state=IDLE, busy=0, done=0, product=0, acc_hi=0, mplr=0, mcand=0, count=0.
REQ-029 Assertion of rst_n mid-RUN SHALL abort the operation immediately, with no done pulse and product=0.
REQ-030 After rst_n is released, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-031 The macro SIGNED_MUL_EN SHALL select signed operation.
REQ-032 With SIGNED_MUL_EN defined:
- an extra input port signed_op (1 bit) is added, sampled with start;
- when signed_op=1, mcand and mplr are loaded with the magnitudes of op_a and op_b, and a neg flag is set to op_a[31]^op_b[31];
- on entry to DONE, product is the 64-bit two's-complement negation of {acc_hi,mplr} when neg=1;
- magnitude and negation logic is internal and does not use the external adder;
- latency is unchanged.
REQ-033 Without SIGNED_MUL_EN, the signed_op port and the neg logic SHALL be absent and operation is unsigned only.

Verification
REQ-034 op_a=3, op_b=5, start for 1 cycle -> done high exactly 33 cycles later, product=64'd15, busy high for 33 cycles.
REQ-035 op_a=op_b=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001; add_cout observed =1 at least once during RUN.
REQ-036 start pulsed again at RUN cycle 10 with different operands -> ignored, product reflects the first operands only.
REQ-037 rst_n driven low at RUN cycle 16, released 2 cycles later -> no done pulse, product=0, next start 7*6 -> product=42.
REQ-038 op_a=0, op_b=32'h12345678 -> product=0 with full 33-cycle latency; start held high -> second done exactly 34 cycles after the first.
REQ-039 SIGNED_MUL_EN defined, signed_op=1, op_a=-3 (32'hFFFFFFFD), op_b=7 -> product=64'hFFFFFFFFFFFFFFEB (-21); signed_op=0 with the same operands -> product=64'h00000006FFFFFFEB.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier: 32x32->64 shift-add multiplier that accumulates through an external 32-bit adder.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op_a, op_b request and operands, sampled in IDLE
//   signed_op         signed request, sampled with start (only when SIGNED_MUL_EN is defined)
//   busy, done        busy in RUN/DONE, done pulses for one cycle in DONE
//   product           result, held until the next DONE
//   add_a, add_b      adder operands, zero outside RUN
//   add_cin           adder carry-in, tied to 0
//   add_sum, add_cout adder result, combinational
// Configuration: define SIGNED_MUL_EN to add two's-complement operation via signed_op.
module seq_multiplier (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
`ifdef SIGNED_MUL_EN
    input  logic        signed_op,
`endif
    output logic        busy,
    output logic        done,
    output logic [63:0] product,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_cin,
    input  logic [31:0] add_sum,
    input  logic        add_cout
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [31:0] mcand, mplr, acc_hi, a_ld, b_ld;
    logic [4:0]  count;
    logic [63:0] shifted, result;
    // Accumulator and multiplier shift as one 64-bit register, carry-out entering at the top.
    assign shifted = {add_cout, add_sum, mplr[31:1]};
`ifdef SIGNED_MUL_EN
    logic neg;
    assign a_ld   = (signed_op && op_a[31]) ? -op_a : op_a;
    assign b_ld   = (signed_op && op_b[31]) ? -op_b : op_b;
    assign result = neg ? -shifted : shifted;
`else
    assign a_ld   = op_a;
    assign b_ld   = op_b;
    assign result = shifted;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    always_comb begin
        state_nx = (state == IDLE) ? (start ? RUN : IDLE) :
                   (state == RUN)  ? ((count == 5'd31) ? DONE : RUN) : IDLE;
        busy     = state != IDLE;
        done     = state == DONE;
        add_a    = (state == RUN) ? acc_hi : 32'd0;
        add_b    = (state == RUN && mplr[0]) ? mcand : 32'd0;
        add_cin  = 1'b0;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mcand   <= '0;
            mplr    <= '0;
            acc_hi  <= '0;
            count   <= '0;
            product <= '0;
`ifdef SIGNED_MUL_EN
            neg     <= 1'b0;
`endif
        end else if (state == IDLE && start) begin
            mcand  <= a_ld;
            mplr   <= b_ld;
            acc_hi <= '0;
            count  <= '0;
`ifdef SIGNED_MUL_EN
            neg    <= signed_op & (op_a[31] ^ op_b[31]);
`endif
        end else if (state == RUN) begin
            {acc_hi, mplr} <= shifted;
            // Last step: capture the result instead of letting count wrap.
            if (count == 5'd31) product <= result;
            else                count   <= count + 5'd1;
        end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: scoreboard bench for seq_multiplier with a behavioural adder model.
module tb_seq_multiplier;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, signed_op = 1'b0;
    logic [31:0] op_a = '0, op_b = '0, add_a, add_b, add_sum;
    logic        add_cin, add_cout, busy, done;
    logic [63:0] product;
    logic [63:0] sb[$];
    int          n_chk = 0, n_fail = 0;
    bit          cout_seen = 1'b0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    seq_multiplier dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
`ifdef SIGNED_MUL_EN
        .signed_op(signed_op),
`endif
        .busy(busy), .done(done), .product(product),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [63:0] s, u;
        s = 64'($signed(a)) * 64'($signed(b));
        u = {32'd0, a} * {32'd0, b};
        return sgn ? s : u;
    endfunction

    always @(negedge clk) begin
        if (busy && !done && add_cout) cout_seen = 1'b1;
        if (done) begin
            if (sb.size() == 0) check("spurious_done", 64'd1, 64'd0);
            else                check("product", product, sb.pop_front());
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [63:0] exp, input int pulse_at, input bit now);
        int lat, nbusy;
        if (!now) @(negedge clk);
        op_a = a; op_b = b; signed_op = sgn; start = 1'b1;
        @(negedge clk);
        sb.push_back(exp);
        start = 1'b0;
        lat = 1;
        nbusy = 0;
        while (lat < 40) begin
            nbusy += int'(busy);
            if (done) break;
            if (lat == pulse_at) begin
                op_a = ~a; op_b = 32'd9; signed_op = 1'b0; start = 1'b1;
            end else start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("latency", 64'(lat), 64'd33);
        check("busy_cycles", 64'(nbusy), 64'd33);
        check("done_add_a", {32'd0, add_a}, 64'd0);
        check("done_add_b", {32'd0, add_b}, 64'd0);
    endtask

    initial begin
        int t;
        logic [31:0] ra, rb;
        #2;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_add_a", {32'd0, add_a}, 64'd0);
        check("rst_add_b", {32'd0, add_b}, 64'd0);
        check("add_cin", {63'd0, add_cin}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // first start right on release
        run_op(32'd3, 32'd5, 1'b0, 64'd15, 0, 1'b1);
        cout_seen = 1'b0;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 0, 1'b0);
        check("cout_seen", {63'd0, cout_seen}, 64'd1);
        // start during RUN must be ignored
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 64'h0B00EA4E242D2080, 10, 1'b0);
        // abort mid-RUN with reset
        @(negedge clk);
        op_a = 32'd1234; op_b = 32'd5678; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_product", product, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd7, 32'd6, 1'b0, 64'd42, 0, 1'b1);
        // zero operand and back-to-back throughput with start held
        sb.push_back(64'd0);
        sb.push_back(64'd0);
        @(negedge clk);
        op_a = 32'd0; op_b = 32'h12345678; start = 1'b1;
        t = 0;
        while (!done && t < 40) begin @(negedge clk); t++; end
        check("b2b_first_latency", 64'(t), 64'd33);
        t = 0;
        do begin @(negedge clk); t++; end while (!done && t < 40);
        check("b2b_spacing", 64'(t), 64'd34);
        start = 1'b0;
        check("b2b_product_held", product, 64'd0);
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op(ra, rb, 1'b0, model(ra, rb, 1'b0), 0, 1'b0);
        end
`ifdef SIGNED_MUL_EN
        run_op(32'hFFFFFFFD, 32'd7, 1'b1, 64'hFFFFFFFFFFFFFFEB, 0, 1'b0);
        run_op(32'hFFFFFFFD, 32'd7, 1'b0, 64'h00000006FFFFFFEB, 0, 1'b0);
        run_op(32'hFFFFFFFB, 32'hFFFFFFFA, 1'b1, 64'd30, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op(ra, rb, 1'b1, model(ra, rb, 1'b1), 0, 1'b0);
        end
`endif
        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
